// File: rtl/riscv32_common.sv
// Shared memory-interface types for the riscv32 core, its vector unit and the memory responders.
// The vector payload width is fixed here because packed struct fields cannot be parameterised.
package riscv32_common;

    localparam int unsigned VECTOR_BITS = 128;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            addr;
        logic [3:0]             do_read;
        logic [3:0]             do_write;
        logic                   is_vector;
        logic [31:0]            data;
        logic [VECTOR_BITS-1:0] vector_data;
    } memory_io_req;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            addr;
        logic [31:0]            data;
        logic                   is_vector;
        logic [VECTOR_BITS-1:0] vector_data;
    } memory_io_rsp;

    localparam memory_io_req memory_io_no_req = '0;
    localparam memory_io_rsp memory_io_no_rsp = '0;

    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{lanes[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/riscv32_word_ram.sv
// Single-port word store: combinational read, byte-enable write on the rising edge.
module riscv32_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/riscv32_vmem_responder.sv
// Memory responder serving scalar word accesses in one cycle and vector accesses one beat per cycle,
// with a single pending slot for requests that arrive while a vector access is in flight.
module riscv32_vmem_responder
    import riscv32_common::*;
#(
    parameter int unsigned VLEN        = 128,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  memory_io_req mem_req,
    output memory_io_rsp mem_rsp,
    output logic         req_ready,
    output logic         overflow
);

    localparam int unsigned NBEATS = VLEN / 32;
    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, VEC_BEAT, VEC_RESP} state_t;

    state_t                 state, state_d;
    logic [BW-1:0]          beat, beat_d;
    logic                   pend_valid;
    memory_io_req           pend_req;
    logic                   out_of_reset;
    memory_io_rsp           rsp_q, rsp_d;

    logic [31:0]            v_addr;
    logic [AW-1:0]          v_base;
    logic                   v_write;
    logic [3:0]             v_mask;
    logic [VECTOR_BITS-1:0] v_data, v_buf, vbuf_d;

    memory_io_req           cur_req;
    logic                   cur_wr, cur_rd, accept_vec;
    logic [3:0]             ram_we;
    logic [AW-1:0]          ram_addr;
    logic [31:0]            ram_wdata, ram_rdata;

    riscv32_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // A parked request always wins the IDLE cycle over a newly arriving one.
    always_comb begin
        cur_req    = pend_valid ? pend_req : mem_req;
        cur_wr     = (cur_req.do_write != 4'b0000);
        cur_rd     = !cur_wr && (cur_req.do_read != 4'b0000);
        accept_vec = 1'b0;
        state_d    = state;
        beat_d     = beat;
        rsp_d      = memory_io_no_rsp;
        vbuf_d     = v_buf;
        ram_we     = '0;
        ram_addr   = cur_req.addr[AW+1:2];
        ram_wdata  = cur_req.data;

        case (state)
            IDLE: begin
                if (cur_req.valid && (cur_wr || cur_rd)) begin
                    if (cur_req.is_vector) begin
                        accept_vec = 1'b1;
                        beat_d     = '0;
                        state_d    = VEC_BEAT;
                    end else if (cur_wr) begin
                        ram_we = cur_req.do_write;
                    end else begin
                        rsp_d.valid = 1'b1;
                        rsp_d.addr  = cur_req.addr;
                        rsp_d.data  = ram_rdata & lane_mask(cur_req.do_read);
                    end
                end
            end
            VEC_BEAT: begin
                ram_addr  = v_base + AW'(beat);
                ram_wdata = v_data[{beat, 5'd0} +: 32];
                if (v_write) begin
                    ram_we = v_mask;
                end else begin
                    vbuf_d[{beat, 5'd0} +: 32] = ram_rdata;
                end
                if (beat == BW'(NBEATS - 1)) begin
                    beat_d = '0;
                    if (v_write) begin
                        state_d = IDLE;
                    end else begin
                        // Response register is loaded here so it is visible during VEC_RESP.
                        state_d           = VEC_RESP;
                        rsp_d.valid       = 1'b1;
                        rsp_d.addr        = v_addr;
                        rsp_d.is_vector   = 1'b1;
                        rsp_d.vector_data = vbuf_d;
                        rsp_d.data        = vbuf_d[31:0];
                    end
                end else begin
                    beat_d = beat + 1'b1;
                end
            end
            VEC_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            beat         <= '0;
            pend_valid   <= 1'b0;
            overflow     <= 1'b0;
            rsp_q        <= memory_io_no_rsp;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_d;
            beat         <= beat_d;
            rsp_q        <= rsp_d;
            out_of_reset <= 1'b1;
            if (state == IDLE) begin
                if (pend_valid) begin
                    pend_valid <= mem_req.valid;
                    pend_req   <= mem_req;
                end
            end else if (mem_req.valid) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_req   <= mem_req;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        v_buf <= vbuf_d;
        if (accept_vec) begin
            v_addr  <= cur_req.addr;
            v_base  <= cur_req.addr[AW+1:2];
            v_write <= cur_wr;
            v_mask  <= cur_req.do_write;
            v_data  <= cur_req.vector_data;
        end
    end

    assign mem_rsp   = rsp_q;
    assign req_ready = out_of_reset && (state == IDLE) && !pend_valid;

endmodule

// File: tb/tb_riscv32_vmem_responder.sv
// Randomised bench for riscv32_vmem_responder against a word-array reference model.
module tb_riscv32_vmem_responder;
    import riscv32_common::*;

    localparam int unsigned VLEN  = 128;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned NB    = VLEN / 32;

    logic         clk = 1'b0;
    logic         reset_n;
    memory_io_req mem_req;
    memory_io_rsp mem_rsp;
    logic         req_ready;
    logic         overflow;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [31:0]  ref_mem [DEPTH];

    always #5 clk = ~clk;

    riscv32_vmem_responder #(
        .VLEN        (VLEN),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_rsp   (mem_rsp),
        .req_ready (req_ready),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic int unsigned widx(input logic [31:0] addr, input int unsigned off);
        return ((int'(addr >> 2)) + off) % DEPTH;
    endfunction

    function automatic memory_io_req mk(input logic is_vec, input logic [31:0] addr, input logic [3:0] rd,
                                        input logic [3:0] wr, input logic [31:0] data, input logic [127:0] vdata);
        memory_io_req r;
        r.valid = 1'b1;
        r.addr = addr;
        r.do_read = rd;
        r.do_write = wr;
        r.is_vector = is_vec;
        r.data = data;
        r.vector_data = vdata;
        return r;
    endfunction

    function automatic logic [127:0] vrnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic memory_io_rsp exp_scalar(input logic [31:0] addr, input logic [3:0] rd);
        memory_io_rsp e;
        e = memory_io_no_rsp;
        e.valid = 1'b1;
        e.addr = addr;
        e.data = ref_mem[widx(addr, 0)] & bmask(rd);
        return e;
    endfunction

    function automatic memory_io_rsp exp_vector(input logic [31:0] addr);
        memory_io_rsp e;
        e = memory_io_no_rsp;
        e.valid = 1'b1;
        e.addr = addr;
        e.is_vector = 1'b1;
        for (int b = 0; b < NB; b++) e.vector_data[32*b +: 32] = ref_mem[widx(addr, b)];
        e.data = e.vector_data[31:0];
        return e;
    endfunction

    // Issues one request when ready and checks its full timing and result against the model.
    task automatic do_txn(input memory_io_req r, output memory_io_rsp got);
        logic wr, rd;
        memory_io_rsp e;
        int unsigned waited;
        got = memory_io_no_rsp;
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_wait", 256'(req_ready), 256'(1));
        wr = (r.do_write != 4'b0000);
        rd = !wr && (r.do_read != 4'b0000);
        mem_req = r;
        tick();
        mem_req = memory_io_no_req;
        if (!r.is_vector || !(wr || rd)) begin
            e = memory_io_no_rsp;
            if (rd && !r.is_vector) e = exp_scalar(r.addr, r.do_read);
            if (wr && !r.is_vector)
                ref_mem[widx(r.addr, 0)] = (ref_mem[widx(r.addr, 0)] & ~bmask(r.do_write)) | (r.data & bmask(r.do_write));
            got = mem_rsp;
            check("scalar_rsp", 256'(mem_rsp), 256'(e));
            check("scalar_ready", 256'(req_ready), 256'(1));
        end else begin
            for (int k = 1; k <= NB; k++) begin
                check("vec_busy", 256'(req_ready), 256'(0));
                check("vec_quiet", 256'(mem_rsp), 256'(memory_io_no_rsp));
                tick();
            end
            if (rd) begin
                check("vresp_busy", 256'(req_ready), 256'(0));
                check("vread_rsp", 256'(mem_rsp), 256'(exp_vector(r.addr)));
                got = mem_rsp;
                tick();
                check("vread_done", 256'(req_ready), 256'(1));
                check("vread_quiet", 256'(mem_rsp), 256'(memory_io_no_rsp));
            end else begin
                for (int b = 0; b < NB; b++)
                    ref_mem[widx(r.addr, b)] = (ref_mem[widx(r.addr, b)] & ~bmask(r.do_write))
                                             | (r.vector_data[32*b +: 32] & bmask(r.do_write));
                check("vwrite_done", 256'(req_ready), 256'(1));
                check("vwrite_quiet", 256'(mem_rsp), 256'(memory_io_no_rsp));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        memory_io_req r;
        memory_io_rsp got;
        logic [127:0] v;

        reset_n = 1'b0;
        mem_req = memory_io_no_req;
        tick();
        tick();
        check("rst_ready", 256'(req_ready), 256'(0));
        check("rst_ovf", 256'(overflow), 256'(0));
        check("rst_rsp", 256'(mem_rsp), 256'(memory_io_no_rsp));
        reset_n = 1'b1;
        tick();
        check("rel_ready", 256'(req_ready), 256'(1));

        for (int i = 0; i < DEPTH; i++) do_txn(mk(1'b0, 32'(i * 4), 4'h0, 4'hF, $urandom, vrnd()), got);

        do_txn(mk(1'b0, 32'h40, 4'h0, 4'hF, 32'hDEADBEEF, vrnd()), got);
        do_txn(mk(1'b0, 32'h40, 4'hF, 4'h0, $urandom, vrnd()), got);
        check("r031_data", 256'(got.data), 256'(32'hDEADBEEF));
        do_txn(mk(1'b0, 32'h40, 4'h0, 4'h3, 32'h0000AAAA, vrnd()), got);
        do_txn(mk(1'b0, 32'h43, 4'hF, 4'h0, $urandom, vrnd()), got);
        check("r032_data", 256'(got.data), 256'(32'hDEADAAAA));

        v = {32'd4, 32'd3, 32'd2, 32'd1};
        do_txn(mk(1'b1, 32'h100, 4'h0, 4'hF, $urandom, v), got);
        do_txn(mk(1'b1, 32'h100, 4'hF, 4'h0, $urandom, vrnd()), got);
        check("r033_vdata", 256'(got.vector_data), 256'(v));

        do_txn(mk(1'b0, 32'h0, 4'h0, 4'hF, 32'hA0A0_0000, vrnd()), got);
        do_txn(mk(1'b0, 32'h4, 4'h0, 4'hF, 32'hA1A1_0001, vrnd()), got);
        do_txn(mk(1'b0, 32'((DEPTH - 2) * 4), 4'h0, 4'hF, 32'hB2B2_0002, vrnd()), got);
        do_txn(mk(1'b0, 32'((DEPTH - 1) * 4), 4'h0, 4'hF, 32'hB3B3_0003, vrnd()), got);
        do_txn(mk(1'b1, 32'((DEPTH - 2) * 4), 4'hF, 4'h0, $urandom, vrnd()), got);
        check("r034_wrap", 256'(got.vector_data), 256'({32'hA1A1_0001, 32'hA0A0_0000, 32'hB3B3_0003, 32'hB2B2_0002}));

        // One request parks in the slot, the next one is dropped.
        check("r035_ready", 256'(req_ready), 256'(1));
        mem_req = mk(1'b1, 32'h100, 4'hF, 4'h0, $urandom, vrnd());
        tick();
        mem_req = mk(1'b0, 32'h20, 4'hF, 4'h0, $urandom, vrnd());
        tick();
        check("r035_ovf_clear", 256'(overflow), 256'(0));
        mem_req = mk(1'b0, 32'h24, 4'h0, 4'hF, 32'h5555_5555, vrnd());
        tick();
        mem_req = memory_io_no_req;
        check("r035_ovf_set", 256'(overflow), 256'(1));
        tick();
        tick();
        check("r035_vrsp", 256'(mem_rsp), 256'(exp_vector(32'h100)));
        tick();
        check("r035_pend_busy", 256'(req_ready), 256'(0));
        check("r035_pend_quiet", 256'(mem_rsp), 256'(memory_io_no_rsp));
        tick();
        check("r035_pend_rsp", 256'(mem_rsp), 256'(exp_scalar(32'h20, 4'hF)));
        check("r035_ready_back", 256'(req_ready), 256'(1));
        do_txn(mk(1'b0, 32'h24, 4'hF, 4'h0, $urandom, vrnd()), got);

        for (int n = 0; n < 150; n++) begin
            logic        vec;
            logic [3:0]  rdm, wrm;
            vec = ($urandom_range(0, 2) == 0);
            rdm = 4'($urandom);
            wrm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rdm = 4'h0;
                wrm = 4'h0;
            end
            do_txn(mk(vec, $urandom, rdm, wrm, $urandom, vrnd()), got);
            if ($urandom_range(0, 3) == 0) tick();
        end
        check("ovf_sticky", 256'(overflow), 256'(1));

        // Reset lands on beat 2 of a vector load.
        mem_req = mk(1'b1, 32'h80, 4'hF, 4'h0, $urandom, vrnd());
        tick();
        mem_req = memory_io_no_req;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check("r036_rsp_rst", 256'(mem_rsp.valid), 256'(0));
        check("r036_ready_rst", 256'(req_ready), 256'(0));
        check("r036_ovf_rst", 256'(overflow), 256'(0));
        reset_n = 1'b1;
        tick();
        check("r036_ready_rel", 256'(req_ready), 256'(1));
        check("r036_ovf_rel", 256'(overflow), 256'(0));
        for (int k = 0; k < NB + 2; k++) begin
            check("r036_no_rsp", 256'(mem_rsp.valid), 256'(0));
            tick();
        end
        do_txn(mk(1'b0, 32'h80, 4'hF, 4'h0, $urandom, vrnd()), got);
        do_txn(mk(1'b1, 32'h80, 4'hF, 4'h0, $urandom, vrnd()), got);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv32_vmem_responder.md
RISCV32_VMEM_RESPONDER -- requirements
Module: riscv32_vmem_responder

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector width in bits; NBEATS = VLEN/32.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, power of two, storage depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_req  input  memory_io_req  request from the scalar core or vector unit: valid, addr, do_read, do_write, is_vector, data, vector_data.
REQ-006 SHALL have port mem_rsp  output  memory_io_rsp  read response: valid, addr, data, is_vector, vector_data.
REQ-007 SHALL have port req_ready  output  1  high when the responder is in IDLE with an empty pending slot.
REQ-008 SHALL have port overflow  output  1  sticky flag, set when a request is dropped.

Function
REQ-009 SHALL classify a request as a write if do_write!=0, else a read if do_read!=0, else a no-op; write takes priority when both are set.
REQ-010 SHALL compute word index = (addr>>2) mod DEPTH_WORDS and SHALL ignore addr[1:0].
REQ-011 SHALL use the FSM states IDLE, VEC_BEAT and VEC_RESP.
REQ-012 SHALL, in IDLE with a scalar write accepted, write data lanes selected by do_write in that cycle and produce no response.
REQ-013 SHALL, in IDLE with a scalar read accepted at cycle T, drive mem_rsp.valid=1 in T+1 for one cycle with addr echoed, is_vector=0, data=stored word with lanes not in do_read zeroed, and vector_data=0.
REQ-014 SHALL, in IDLE with a vector request accepted, latch addr, kind, do_write and vector_data, set beat=0 and enter VEC_BEAT.
REQ-015 SHALL, in VEC_BEAT, each cycle access word index + beat (mod DEPTH_WORDS), using lane beat of vector_data (writes, do_write mask) or capturing into lane beat of the assembly buffer (reads), then increment beat.
REQ-016 SHALL, on the beat NBEATS-1, go to VEC_RESP for a read or to IDLE for a write.
REQ-017 SHALL, in VEC_RESP, drive mem_rsp.valid=1, is_vector=1, addr=latched addr, vector_data=buffer and data=lane 0 for one cycle, then return to IDLE.
REQ-018 SHALL give a vector read accepted at T its response at T+NBEATS+1, and SHALL complete a vector write in cycles T+1..T+NBEATS.
REQ-019 SHALL, when mem_req.valid arrives while not in IDLE, capture it into a one-entry pending slot if the slot is empty.
REQ-020 SHALL, when mem_req.valid arrives while not in IDLE and the pending slot is full, drop the request and set overflow.
REQ-021 SHALL, on entering IDLE with the pending slot full, service the pending request in that IDLE cycle ahead of any new mem_req; if a new mem_req.valid also arrives in that cycle, it SHALL move into the slot.
REQ-022 SHALL drive mem_rsp equal to memory_io_no_rsp (all fields zero) whenever no response is valid.
REQ-023 SHALL treat no-op requests as accepted with no storage or response effect.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge, set state=IDLE, beat=0, pending slot empty, overflow=0, mem_rsp=memory_io_no_rsp and req_ready=0.
REQ-025 SHALL drive req_ready=1 in the first cycle after reset_n deasserts.
REQ-026 SHALL abandon any in-flight vector access at reset with no response; beats already written remain in storage.
REQ-027 SHALL NOT initialise storage contents at reset.

Structure
REQ-028 SHALL take memory_io_req, memory_io_rsp and memory_io_no_req from riscv32_common, and SHALL have the new constant memory_io_no_rsp added there.
REQ-029 SHALL keep the FSM state enum local to the module.
REQ-030 SHALL instantiate sub-module riscv32_word_ram: single port, DEPTH_WORDS x 32, combinational read, synchronous byte-enable write.

Verification
REQ-031 Scalar write addr=0x40 data=0xDEADBEEF do_write=1111, then read do_read=1111 -> rsp.valid one cycle after the read, data=0xDEADBEEF, is_vector=0.
REQ-032 Partial write do_write=0011 data=0x0000AAAA to the 0xDEADBEEF word, then read -> data=0xDEADAAAA.
REQ-033 Vector store addr=0x100 vector_data={4,3,2,1}, then vector load 0x100 at T -> rsp at T+5, vector_data={4,3,2,1}, req_ready low T+1..T+5.
REQ-034 Vector load at word DEPTH_WORDS-2 -> lanes 2,3 read words 0 and 1 (wrap).
REQ-035 Two requests during VEC_BEAT -> first pending and serviced in the next IDLE, second dropped, overflow=1 until reset.
REQ-036 reset_n=0 during VEC_BEAT beat 2 of a load -> no rsp.valid, req_ready=1 the cycle after release, overflow=0.
